// File: rtl/hilo_div_pkg.sv
// Shared definitions for the HI/LO divide unit: FSM states, widths, flag bit positions.
package hilo_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    // Bit positions inside the 4-bit {C,V,N,Z} flags word
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
import hilo_div_pkg::*;

module div_step #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] remainder,
    input  logic [WIDTH-1:0] quotient,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_remainder,
    output logic [WIDTH-1:0] next_quotient
);

    // The shifted partial remainder needs one extra bit; a successful
    // trial subtraction always brings it back under WIDTH bits.
    logic [WIDTH:0] shifted;
    logic           fits;

    // Shift remainder:quotient left, trial-subtract, keep result if no borrow
    always_comb begin
        shifted        = {remainder, quotient[WIDTH-1]};
        fits           = (shifted >= {1'b0, divisor});
        next_remainder = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
        next_quotient  = {quotient[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/hilo_divide_unit.sv
// Iterative DIV/DIVU engine holding the architectural HI (remainder) and LO (quotient).
import hilo_div_pkg::*;

module hilo_divide_unit #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [3:0]       flags
);

    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;     // raw dividend in PREP, then the shifting quotient
    logic [WIDTH-1:0] dvs;     // raw divisor in PREP, then its magnitude
    logic             sgn;
    logic             q_neg;
    logic             r_neg;
    logic             ovf;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .remainder      (rem),
        .quotient       (quo),
        .divisor        (dvs),
        .next_remainder (step_rem),
        .next_quotient  (step_quo)
    );

    // Operand magnitudes for PREP and sign-corrected results for FIX
    always_comb begin
        a_mag = (sgn && quo[WIDTH-1]) ? '0 - quo : quo;
        b_mag = (sgn && dvs[WIDTH-1]) ? '0 - dvs : dvs;
        q_fin = q_neg ? '0 - quo : quo;
        r_fin = r_neg ? '0 - rem : rem;
    end

    // Divider FSM, HI/LO registers and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            sgn   <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            flags <= '0;
        end else begin
            done <= 1'b0;
            if (!busy && mthi) hi <= wr_data;
            if (!busy && mtlo) lo <= wr_data;

            case (state)
                IDLE, DONE: begin
                    // Raw operands are captured here and turned into magnitudes in PREP
                    if (start) begin
                        quo   <= dividend;
                        dvs   <= divisor;
                        sgn   <= is_signed;
                        busy  <= 1'b1;
                        state <= PREP;
                    end else begin
                        state <= IDLE;
                    end
                end
                PREP: begin
                    quo   <= a_mag;
                    dvs   <= b_mag;
                    rem   <= '0;
                    cnt   <= '0;
                    q_neg <= sgn && (quo[WIDTH-1] ^ dvs[WIDTH-1]);
                    r_neg <= sgn && quo[WIDTH-1];
                    ovf   <= sgn && (quo == MOST_NEG) && (dvs == '1);
                    if (dvs == '0) begin
                        flags[FLAG_C] <= 1'b0;
                        flags[FLAG_V] <= 1'b1;
                        flags[FLAG_N] <= lo[WIDTH-1];
                        flags[FLAG_Z] <= (lo == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) state <= FIX;
                end
                FIX: begin
                    hi            <= r_fin;
                    lo            <= q_fin;
                    flags[FLAG_C] <= 1'b0;
                    flags[FLAG_V] <= ovf;
                    flags[FLAG_N] <= q_fin[WIDTH-1];
                    flags[FLAG_Z] <= (q_fin == '0);
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    state         <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_divide_unit.sv
// Self-checking bench for hilo_divide_unit against an arithmetic reference model.
module tb_hilo_divide_unit;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        start     = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend  = '0;
    logic [31:0] divisor   = '0;
    logic        mthi      = 1'b0;
    logic        mtlo      = 1'b0;
    logic [31:0] wr_data   = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  flags;

    int passed = 0;
    int total  = 0;

    // Architectural HI/LO as the model expects them to be
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    hilo_divide_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // MIPS division semantics computed with 64-bit host arithmetic
    task automatic ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] h, output logic [31:0] l, output logic [3:0] f);
        longint na;
        longint nb;
        longint q;
        longint r;
        bit     v;
        if (b == 32'd0) begin
            h = exp_hi;
            l = exp_lo;
            v = 1'b1;
        end else begin
            na = s ? longint'($signed(a)) : longint'(a);
            nb = s ? longint'($signed(b)) : longint'(b);
            q  = na / nb;
            r  = na % nb;
            h  = r[31:0];
            l  = q[31:0];
            v  = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end
        f = {1'b0, v, l[31], (l == 32'd0)};
    endtask

    // Issue one divide, optionally disturb it mid-RUN or pair it with an MTLO,
    // then check latency, busy/done and the results; returns in the done cycle.
    task automatic run_div(input string tag, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input bit disturb,
                           input bit with_mtlo, input logic [31:0] wdata);
        logic [31:0] eh;
        logic [31:0] el;
        logic [3:0]  ef;
        int          lat;
        int          exp_lat;
        if (with_mtlo) exp_lo = wdata;
        ref_div(s, a, b, eh, el, ef);
        exp_lat = (b == 32'd0) ? 2 : 35;
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        if (with_mtlo) begin
            mtlo    = 1'b1;
            wr_data = wdata;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        mtlo  = 1'b0;
        lat   = 1;
        check({tag, "/busy_rise"}, 32'(busy), 32'd1);
        while (!done && lat < 60) begin
            if (disturb && lat == 12) begin
                start   = 1'b1;
                mthi    = 1'b1;
                mtlo    = 1'b1;
                wr_data = 32'h1234;
            end
            @(posedge clk);
            #1;
            lat++;
            if (disturb) begin
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
            end
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/busy_fall"}, 32'(busy), 32'd0);
        check({tag, "/hi"}, hi, eh);
        check({tag, "/lo"}, lo, el);
        check({tag, "/flags"}, 32'(flags), 32'(ef));
        exp_hi = eh;
        exp_lo = el;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        #12;
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/hi", hi, 32'd0);
        check("rst/lo", lo, 32'd0);
        check("rst/flags", 32'(flags), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed test-plan cases with literal expectations
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0, 1'b0, '0);
        check("divu_100_7/lo_lit", lo, 32'd14);
        check("divu_100_7/hi_lit", hi, 32'd2);
        check("divu_100_7/flags_lit", 32'(flags), 32'h0);
        @(posedge clk);
        #1;
        check("divu_100_7/done_one_cycle", 32'(done), 32'd0);

        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0);
        check("div_m7_2/lo_lit", lo, 32'hFFFF_FFFD);
        check("div_m7_2/hi_lit", hi, 32'hFFFF_FFFF);
        check("div_m7_2/flags_lit", 32'(flags), 32'h2);

        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
        check("div_ovf/lo_lit", lo, 32'h8000_0000);
        check("div_ovf/hi_lit", hi, 32'd0);
        check("div_ovf/flags_lit", 32'(flags), 32'h6);

        // Preload HI/LO, then divide by zero must leave them intact
        @(negedge clk);
        mthi    = 1'b1;
        wr_data = 32'h0000_AAAA;
        @(negedge clk);
        mthi    = 1'b0;
        mtlo    = 1'b1;
        wr_data = 32'h0000_5555;
        @(negedge clk);
        mtlo    = 1'b0;
        exp_hi  = 32'h0000_AAAA;
        exp_lo  = 32'h0000_5555;
        check("preload/hi", hi, 32'h0000_AAAA);
        check("preload/lo", lo, 32'h0000_5555);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, '0);
        check("divu_5_0/hi_lit", hi, 32'h0000_AAAA);
        check("divu_5_0/lo_lit", lo, 32'h0000_5555);
        check("divu_5_0/flags_lit", 32'(flags), 32'h4);

        // start/mthi/mtlo during RUN are ignored; MTHI in the DONE cycle lands
        run_div("disturb", 1'b0, 32'd1000003, 32'd17, 1'b1, 1'b0, '0);
        mthi    = 1'b1;
        wr_data = 32'h1234;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        check("done_mthi/hi", hi, 32'h1234);
        check("done_mthi/lo", lo, exp_lo);
        exp_hi = 32'h1234;

        // MTLO together with start: divide-by-zero keeps the MTLO value
        run_div("mtlo_start_div0", 1'b0, 32'd7, 32'd0, 1'b0, 1'b1, 32'h0000_BEEF);
        // MTLO together with start: a real result overwrites it
        run_div("mtlo_start_div", 1'b1, 32'hFFFF_FF00, 32'd9, 1'b0, 1'b1, 32'h0BAD_0BAD);

        // Randomized divides against the model
        for (int i = 0; i < 10; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            if ($urandom_range(0, 5) == 0)      rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom;
            else                                rb = 32'($urandom_range(1, 300));
            run_div("random", rs, ra, rb, 1'b0, 1'($urandom_range(0, 1)), $urandom);
        end

        // Reset in the middle of RUN
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd123456789;
        divisor   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("midrun/busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrun/busy", 32'(busy), 32'd0);
        check("midrun/done", 32'(done), 32'd0);
        check("midrun/hi", hi, 32'd0);
        check("midrun/lo", lo, 32'd0);
        check("midrun/flags", 32'(flags), 32'd0);
        exp_hi = '0;
        exp_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        check("midrun/no_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 1'b0, 1'b0, '0);
        check("divu_9_3/lo_lit", lo, 32'd3);
        check("divu_9_3/hi_lit", hi, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hilo_divide_unit.md
# hilo_divide_unit

Multi-cycle divider and HI/LO register file for the EX stage of the pipelined MIPS core. It executes DIV/DIVU iteratively and holds the architectural HI/LO registers. It also accepts MTHI/MTLO writes of the ALU result word `Y_lo`, and drives `busy` so the hazard unit can stall MFHI/MFLO and any new divide.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is verified.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a divide; sampled only when `busy`=0.
- `is_signed`  in  1  1 = DIV, 0 = DIVU; sampled with `start`.
- `dividend`  in  WIDTH  rs operand.
- `divisor`  in  WIDTH  rt operand.
- `mthi`, `mtlo`  in  1 each  write `wr_data` into HI / LO.
- `wr_data`  in  WIDTH  ALU result `Y_lo`.
- `busy`  out  1  high in PREP, RUN, FIX.
- `done`  out  1  high for exactly the one cycle in DONE.
- `hi`, `lo`  out  WIDTH each  architectural HI (remainder) and LO (quotient).
- `flags`  out  4  {C,V,N,Z} of the last divide.
  - C = 0.
  - V = divide-by-zero or signed overflow.
  - N = `lo[WIDTH-1]`.
  - Z = (`lo`==0).

## Operation
- Reset (asynchronous, any state): state=IDLE, `hi`=`lo`=0, `flags`=0, `busy`=0, `done`=0, iteration counter=0.
- States and transitions:
  - IDLE: `start` -> PREP.
  - PREP: latch |dividend|, |divisor|, quotient sign, remainder sign. Signed magnitudes are taken only when `is_signed`=1. divisor==0 -> DONE. Otherwise -> RUN with counter=0.
  - RUN: one restoring step per cycle: shift remainder:quotient left 1, trial-subtract the divisor, set the quotient bit if no borrow. Counter==WIDTH-1 -> FIX.
  - FIX: negate the quotient if the signs differ (signed only). Negate the remainder if the dividend was negative. Write HI=remainder, LO=quotient and update `flags` on the exiting edge. -> DONE.
  - DONE: `done`=1. -> IDLE, or directly -> PREP if `start`=1.
- Divide-by-zero: HI/LO are unchanged. `flags`={0,1,N,Z}, with N/Z computed from the unchanged `lo`. `flags` is written on the PREP->DONE edge.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, V=1, full latency.
- `mthi`/`mtlo`: write on the next edge when `busy`=0, which includes IDLE and DONE. Ignored while `busy`=1. They do not change `flags`.
- `start` while `busy`=1 is ignored. There is no queue, so the hazard unit must hold the instruction.
- `start` together with `mtlo`/`mthi` in IDLE: both take effect. The divide result later overwrites HI/LO.
- Remainder sign follows the dividend. Quotient truncates toward zero (MIPS semantics).

## Timing
- `start` sampled at edge E0.
  - PREP occupies the cycle after E0.
  - RUN occupies E1..E32 (WIDTH cycles).
  - FIX is entered at E33, and the HI/LO write happens at E34.
  - `done`=1 and the new `hi`/`lo` are visible in the cycle after E34.
  - Latency start -> done = WIDTH+3 = 35 cycles.
- Divide-by-zero: `done` in the cycle after E1 (2 cycles).
- `busy` rises in the cycle after E0 and falls in the same cycle `done` rises.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset asserted mid-RUN aborts the divide, with no `done` and HI/LO=0. The first `start` after reset release is accepted normally.

## Structure
- Shared package `hilo_div_pkg` holds:
  - the state enum (IDLE, PREP, RUN, FIX, DONE);
  - `DIV_WIDTH`=32;
  - the counter width = $clog2(`DIV_WIDTH`);
  - the flag bit indices C=3, V=2, N=1, Z=0.
- One combinational sub-module `div_step` implements a single restoring iteration. Inputs: remainder, quotient, divisor. Outputs: next remainder, next quotient.
- The top level holds the FSM, the counter, the sign handling and the HI/LO registers.

## Test plan
- DIVU 100 / 7: `done` exactly 35 cycles after `start`, LO=14, HI=2, flags=0000.
- DIV 0xFFFFFFF9 (-7) / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF, flags={0,0,1,0}.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, V=1, N=1 after 35 cycles.
- DIVU 5 / 0 with HI=0xAAAA, LO=0x5555 preloaded via MTHI/MTLO:
  - `done` after 2 cycles;
  - HI/LO unchanged;
  - V=1.
- During RUN, pulse `start`, `mthi` (`wr_data`=0x1234) and `mtlo`:
  - all are ignored;
  - the result equals that of an undisturbed run;
  - a `mthi` in the DONE cycle then sets HI=0x1234.
- Assert `reset_n`=0 at RUN iteration 10:
  - `busy`, `done`, `hi`, `lo` and `flags` go to 0 immediately, with no `done`;
  - DIVU 9 / 3 after release gives LO=3, HI=0.
